product_sink: RTL and testbench
===============================

// Module: product_sink
// PURPOSE
//  I/O-bus slave that receives the 16-bit products the multiply-loop master writes as two bytes
//  (high byte, then low byte) to BASE, reassembles each pair into a word and buffers it in a FIFO.
//  Drains words to a downstream consumer over valid/ready; exposes a status byte at BASE+1 and a
//  control byte at BASE+2. Shares clock and bus (addr/data/ior_/iow_) with the master; single master.
// PARAMETERS
//  BASE      16'h0140  product data port; status = BASE+1, control = BASE+2
//  DEPTH     4         FIFO depth in 16-bit words, power of 2, 2..8
// PORTS
//  clock      in     1   system clock, all state on posedge
//  reset      in     1   synchronous, active-high reset
//  addr       in     16  bus address from master
//  data       inout  8   bus data; driven only during status reads, else 8'hZZ
//  ior_       in     1   read strobe, active low
//  iow_       in     1   write strobe, active low
//  out_valid  out    1   FIFO head word available
//  out_data   out    16  FIFO head word, {high byte, low byte}
//  out_ready  in     1   consumer accepts head word this cycle
//  overflow   out    1   sticky: a word was dropped because FIFO full
// BEHAVIOUR
//  - Clock and reset: one clock; reset is synchronous and active-high. Reset clears FIFO and pointers,
//    phase=HI, hold=0, overflow=0, out_valid=0, out_data=0, data released (Z).
//  - Write capture: any posedge with iow_==0 and addr==BASE loads hold<=data and sets pend.
//    The first later posedge with iow_==1 commits (pend clears). Only one commit per strobe,
//    however many cycles iow_ stays low.
//  - Phase FSM {HI, LO}: commit in HI -> hi_byte<=hold, go LO. Commit in LO -> push {hi_byte,hold}, go HI.
//  - Control: commit of a write to BASE+2 with data[0]==1 flushes FIFO, forces phase=HI, clears pend
//    and overflow. data[0]==0 -> no effect. Writes to other addresses are ignored.
//  - Push: accepted if !full, or full and pop happens the same cycle. Otherwise the word is dropped
//    and overflow<=1. Phase still returns to HI.
//  - Pop: out_valid && out_ready at a posedge. out_data/out_valid are registered. A word pushed at
//    edge N is visible at the output after edge N (latency 1). No combinational bypass.
//  - Push and pop in the same cycle on an empty FIFO: pop is impossible (out_valid=0), push proceeds.
//  - Status read: while ior_==0 && addr==BASE+1, drive data = {overflow, full, 2'b00, count[3:0]}
//    (combinational from registers). On the posedge where ior_ is sampled 1 after a sampled status
//    read, clear overflow. A push-drop in that same cycle wins and sets overflow=1.
//  - Reads of BASE/BASE+2: not decoded, data stays Z.
//  - Flush and push in the same cycle: flush wins and the word is discarded.
//    Flush and pop in the same cycle: flush wins.
//  - Reset mid-pair: the partial hi_byte is lost and the next data write is treated as a high byte.
//  - count: 0..DEPTH, pointers are log2(DEPTH)+1 bits. full = count==DEPTH.
// STRUCTURE
//  - Package product_bus_pkg: PROD_DATA_ADDR=16'h0140, PROD_STAT_ADDR=16'h0141,
//    PROD_CTRL_ADDR=16'h0142, phase enum {PH_HI, PH_LO}, status bit positions.
//  - Sub-module product_fifo #(WIDTH=16, DEPTH): sync FIFO with push/pop/flush, full, count,
//    registered head and valid.
//  - Top: strobe edge/commit logic, phase FSM, status mux, tri-state driver, overflow flag.
// TESTING
//  1. Reset, then write 8'h12 then 8'h34 to 16'h0140 (iow_ low 1 cycle each) -> one cycle after
//     the second commit, out_valid=1 and out_data=16'h1234; out_ready=1 -> out_valid=0 next cycle.
//  2. Hold iow_ low for 3 cycles on a single 8'hAB write -> exactly one commit, phase=LO, no push.
//  3. out_ready=0, push 5 pairs with DEPTH=4 -> count=4, overflow=1, status read gives 8'hC4.
//     After ior_ rises, overflow=0. FIFO holds the first 4 words in order.
//  4. FIFO full with out_ready=1 on the commit cycle of the 5th pair -> no drop, overflow=0,
//     count stays 4, output order preserved.
//  5. Write 8'h01 to 16'h0142 after a high byte only -> FIFO empty and phase=HI.
//     Next pair 8'h56, 8'h78 -> out_data=16'h5678.
//  6. Assert reset between high and low byte, then write 8'h9A, 8'hBC -> out_data=16'h9ABC.
//     data is Z whenever the bus is not doing a status read.

Source files
------------

// File: rtl/product_bus_pkg.sv
// Shared constants and types for the product sink bus slave: register
// addresses on the I/O bus, the byte-pairing phase and status bit layout.
package product_bus_pkg;

   localparam logic [15:0] PROD_DATA_ADDR = 16'h0140;
   localparam logic [15:0] PROD_STAT_ADDR = 16'h0141;
   localparam logic [15:0] PROD_CTRL_ADDR = 16'h0142;

   // Which byte of a product the next data write carries
   typedef enum logic {
      PH_HI = 1'b0,
      PH_LO = 1'b1
   } phase_t;

   // Status byte layout: {overflow, full, 2'b00, count[3:0]}
   localparam int STAT_OVF_BIT  = 7;
   localparam int STAT_FULL_BIT = 6;
   localparam int STAT_CNT_MSB  = 3;

   // Control byte: bit 0 requests a flush
   localparam int CTRL_FLUSH_BIT = 0;

endpackage

// File: rtl/product_fifo.sv
// Synchronous word FIFO with a registered head word and valid flag, so the
// consumer only ever sees flopped outputs. A pushed word appears at the head
// one edge after it is written, never combinationally.
module product_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_pushData,
   input  logic                     i_pop,
   input  logic                     i_flush,
   output logic                     o_full,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic                     o_valid,
   output logic [WIDTH-1:0]         o_data
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wrPtr;
   logic [AW:0]      r_rdPtr;

   logic             w_pop;
   logic             w_push;
   logic [AW:0]      w_rdNext;
   logic [AW:0]      w_remain;
   logic [AW:0]      w_popInc;

   // Occupancy comes straight from the extra-bit pointers; a pop only counts
   // when a head word is actually presented, and a full FIFO still accepts
   // a push when the head leaves in the same cycle.
   assign o_count  = r_wrPtr - r_rdPtr;
   assign o_full   = (o_count == FULL_COUNT);
   assign w_pop    = i_pop & o_valid;
   assign w_push   = i_push & (~o_full | w_pop) & ~i_flush;
   assign w_popInc = {{AW{1'b0}}, w_pop};
   assign w_rdNext = r_rdPtr + w_popInc;
   assign w_remain = o_count - w_popInc;

   // Storage array; written only when a push is accepted
   always_ff @(posedge clock) begin
      if (w_push) begin
         r_mem[r_wrPtr[AW-1:0]] <= i_pushData;
      end
   end

   // Pointers and the registered head: when the FIFO would otherwise be
   // empty after this edge, the incoming word becomes the head directly.
   always_ff @(posedge clock) begin
      if (reset || i_flush) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         o_valid <= 1'b0;
         o_data  <= '0;
      end else begin
         if (w_push) begin
            r_wrPtr <= r_wrPtr + 1'b1;
         end
         r_rdPtr <= w_rdNext;
         if (w_remain != '0) begin
            o_valid <= 1'b1;
            o_data  <= r_mem[w_rdNext[AW-1:0]];
         end else if (w_push) begin
            o_valid <= 1'b1;
            o_data  <= i_pushData;
         end else begin
            o_valid <= 1'b0;
            o_data  <= '0;
         end
      end
   end

endmodule

// File: rtl/product_sink.sv
// I/O-bus slave collecting 16-bit products written as high byte then low
// byte to BASE. Each write strobe is captured while iow_ is low and commits
// once on the first edge with iow_ high. Completed words go into a FIFO that
// drains over valid/ready; BASE+1 reads back status, BASE+2 accepts a flush.
module product_sink
   import product_bus_pkg::*;
#(
   parameter logic [15:0] BASE  = PROD_DATA_ADDR,
   parameter int          DEPTH = 4
) (
   input  logic         clock,
   input  logic         reset,
   input  logic [15:0]  addr,
   inout  wire  [7:0]   data,
   input  logic         ior_,
   input  logic         iow_,
   output logic         out_valid,
   output logic [15:0]  out_data,
   input  logic         out_ready,
   output logic         overflow
);

   localparam logic [15:0] STAT_ADDR = BASE + 16'd1;
   localparam logic [15:0] CTRL_ADDR = BASE + 16'd2;

   phase_t              r_phase;
   logic [7:0]          r_hold;
   logic [7:0]          r_hiByte;
   logic                r_pendData;
   logic                r_pendCtrl;
   logic                r_statRd;
   logic                r_overflow;

   logic                w_commitData;
   logic                w_flush;
   logic                w_pushReq;
   logic                w_pop;
   logic                w_full;
   logic                w_drop;
   logic                w_statRd;
   logic [7:0]          w_statByte;
   logic [$clog2(DEPTH):0] w_count;

   // A commit happens on the edge where iow_ is back high with a capture
   // pending; a control commit only acts when its flush bit was set.
   assign w_commitData = r_pendData & iow_;
   assign w_flush      = r_pendCtrl & iow_ & r_hold[CTRL_FLUSH_BIT];
   assign w_pushReq    = w_commitData & (r_phase == PH_LO) & ~w_flush;
   assign w_pop        = out_valid & out_ready;
   assign w_drop       = w_pushReq & w_full & ~w_pop;
   assign w_statRd     = ~ior_ & (addr == STAT_ADDR);
   assign overflow     = r_overflow;

   // Status byte assembled from registered state only
   always_comb begin
      w_statByte                  = '0;
      w_statByte[STAT_CNT_MSB:0]  = 4'(w_count);
      w_statByte[STAT_FULL_BIT]   = w_full;
      w_statByte[STAT_OVF_BIT]    = r_overflow;
   end

   // The bus is only ever driven while a status read is in progress
   assign data = w_statRd ? w_statByte : 8'hzz;

   // Strobe capture, byte-pairing phase and the sticky overflow flag
   always_ff @(posedge clock) begin
      if (reset) begin
         r_phase    <= PH_HI;
         r_hold     <= '0;
         r_hiByte   <= '0;
         r_pendData <= 1'b0;
         r_pendCtrl <= 1'b0;
         r_statRd   <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         if (!iow_) begin
            if (addr == BASE) begin
               r_hold     <= data;
               r_pendData <= 1'b1;
            end else if (addr == CTRL_ADDR) begin
               r_hold     <= data;
               r_pendCtrl <= 1'b1;
            end
         end else begin
            r_pendData <= 1'b0;
            r_pendCtrl <= 1'b0;
         end

         if (w_statRd) begin
            r_statRd <= 1'b1;
         end else if (ior_) begin
            r_statRd <= 1'b0;
         end

         if (w_flush) begin
            r_phase    <= PH_HI;
            r_overflow <= 1'b0;
         end else begin
            if (r_statRd && ior_) begin
               r_overflow <= 1'b0;
            end
            if (w_drop) begin
               r_overflow <= 1'b1;
            end
            if (w_commitData) begin
               case (r_phase)
                  PH_HI: begin
                     r_hiByte <= r_hold;
                     r_phase  <= PH_LO;
                  end
                  PH_LO: begin
                     r_phase  <= PH_HI;
                  end
                  default: r_phase <= PH_HI;
               endcase
            end
         end
      end
   end

   product_fifo #(
      .WIDTH (16),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clock      (clock),
      .reset      (reset),
      .i_push     (w_pushReq),
      .i_pushData ({r_hiByte, r_hold}),
      .i_pop      (out_ready),
      .i_flush    (w_flush),
      .o_full     (w_full),
      .o_count    (w_count),
      .o_valid    (out_valid),
      .o_data     (out_data)
   );

endmodule

// File: tb/tb_product_sink.sv
// Bench for product_sink: directed bus scenarios followed by randomized bus
// traffic, every cycle compared against a queue-based model of the sink.
module tb_product_sink;

   localparam logic [15:0] BASE  = 16'h0140;
   localparam logic [15:0] STAT  = 16'h0141;
   localparam logic [15:0] CTRL  = 16'h0142;
   localparam int          DEPTH = 4;

   logic        clock;
   logic        reset;
   logic [15:0] addr;
   wire  [7:0]  data;
   logic        iorN;
   logic        iowN;
   logic        outValid;
   logic [15:0] outData;
   logic        outReady;
   logic        overflow;

   logic [7:0]  tbData;
   logic        tbDrive;
   logic        forceDrive;
   logic [7:0]  lastStatus;

   int          checks;
   int          errors;

   // Reference model state
   logic [15:0] mQ[$];
   logic        mPhaseHi;
   logic [7:0]  mHi;
   logic [7:0]  mHold;
   logic        mPendData;
   logic        mPendCtrl;
   logic        mOvf;
   logic        mStatSeen;

   assign data = tbDrive ? tbData : 8'hzz;

   product_sink #(
      .BASE  (BASE),
      .DEPTH (DEPTH)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .addr      (addr),
      .data      (data),
      .ior_      (iorN),
      .iow_      (iowN),
      .out_valid (outValid),
      .out_data  (outData),
      .out_ready (outReady),
      .overflow  (overflow)
   );

   // Free-running clock
   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   function automatic logic [7:0] modelStatus();
      logic [7:0] s;
      s = {mOvf, (mQ.size() == DEPTH), 2'b00, 4'(mQ.size())};
      return s;
   endfunction

   // One clock edge of the sink's behaviour, from the bus rules
   task automatic modelStep(input logic rst, input logic iow, input logic ior,
                            input logic [15:0] a, input logic [7:0] d, input logic rdy);
      logic pop;
      if (rst) begin
         mQ.delete();
         mPhaseHi  = 1'b1;
         mHi       = 8'h00;
         mHold     = 8'h00;
         mPendData = 1'b0;
         mPendCtrl = 1'b0;
         mOvf      = 1'b0;
         mStatSeen = 1'b0;
         return;
      end
      pop = (mQ.size() > 0) && rdy;
      if (iow && mPendCtrl && mHold[0]) begin
         mQ.delete();
         mPhaseHi = 1'b1;
         mOvf     = 1'b0;
      end else begin
         if (mStatSeen && ior) mOvf = 1'b0;
         if (pop) void'(mQ.pop_front());
         if (iow && mPendData) begin
            if (mPhaseHi) begin
               mHi      = mHold;
               mPhaseHi = 1'b0;
            end else begin
               mPhaseHi = 1'b1;
               if (mQ.size() < DEPTH) mQ.push_back({mHi, mHold});
               else mOvf = 1'b1;
            end
         end
      end
      if (!iow) begin
         if (a == BASE) begin
            mHold     = d;
            mPendData = 1'b1;
         end else if (a == CTRL) begin
            mHold     = d;
            mPendCtrl = 1'b1;
         end
      end else begin
         mPendData = 1'b0;
         mPendCtrl = 1'b0;
      end
      if (!ior && a == STAT) mStatSeen = 1'b1;
      else if (ior) mStatSeen = 1'b0;
   endtask

   // Drive one cycle of bus inputs, advance one edge, compare with the model
   task automatic applyStimulus(input logic rst, input logic iow, input logic ior,
                                input logic [15:0] a, input logic [7:0] d, input logic rdy);
      reset    = rst;
      iowN     = iow;
      iorN     = ior;
      addr     = a;
      tbData   = d;
      outReady = rdy;
      tbDrive  = !iow || forceDrive;
      #1;
      if (!ior && a == STAT && !rst) begin
         lastStatus = data;
         checkOutput("statusByte", 32'(data), 32'(modelStatus()));
      end
      if (forceDrive) checkOutput("busRelease", 32'(data), 32'(d));
      @(posedge clock);
      modelStep(rst, iow, ior, a, d, rdy);
      #1;
      checkOutput("outValid", 32'(outValid), 32'(mQ.size() > 0));
      if (mQ.size() > 0) checkOutput("outData", 32'(outData), 32'(mQ[0]));
      checkOutput("overflowPin", 32'(overflow), 32'(mOvf));
   endtask

   task automatic writeByte(input logic [15:0] a, input logic [7:0] d, input int lowCycles,
                            input logic rdyLow, input logic rdyCommit);
      for (int i = 0; i < lowCycles; i++) applyStimulus(1'b0, 1'b0, 1'b1, a, d, rdyLow);
      applyStimulus(1'b0, 1'b1, 1'b1, a, d, rdyCommit);
   endtask

   task automatic statusRead(input logic rdy);
      applyStimulus(1'b0, 1'b1, 1'b0, STAT, 8'h00, rdy);
      applyStimulus(1'b0, 1'b1, 1'b1, STAT, 8'h00, rdy);
   endtask

   task automatic idle(input int n, input logic rdy);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b1, 1'b1, 16'h0000, 8'h00, rdy);
   endtask

   // Directed scenarios, then randomized traffic
   initial begin
      checks     = 0;
      errors     = 0;
      forceDrive = 1'b0;
      tbDrive    = 1'b0;
      tbData     = 8'h00;
      lastStatus = 8'h00;
      modelStep(1'b1, 1'b1, 1'b1, 16'h0, 8'h0, 1'b0);

      // Reset state
      applyStimulus(1'b1, 1'b1, 1'b1, 16'h0000, 8'h00, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b1, 16'h0000, 8'h00, 1'b0);
      checkOutput("rstValid", 32'(outValid), 32'h0);
      checkOutput("rstData", 32'(outData), 32'h0);
      checkOutput("rstOverflow", 32'(overflow), 32'h0);
      statusRead(1'b0);
      checkOutput("rstStatus", 32'(lastStatus), 32'h00);

      // Basic pair reassembly
      writeByte(BASE, 8'h12, 1, 1'b0, 1'b0);
      writeByte(BASE, 8'h34, 1, 1'b0, 1'b0);
      checkOutput("pairValid", 32'(outValid), 32'h1);
      checkOutput("pair1234", 32'(outData), 32'h1234);
      idle(1, 1'b1);
      checkOutput("popEmpty", 32'(outValid), 32'h0);

      // Long strobe commits once
      writeByte(BASE, 8'hAB, 3, 1'b0, 1'b0);
      checkOutput("longNoPush", 32'(outValid), 32'h0);
      writeByte(BASE, 8'hCD, 1, 1'b0, 1'b0);
      checkOutput("longABCD", 32'(outData), 32'hABCD);
      idle(1, 1'b1);

      // Overflow on a fifth pair, status then cleared by the read
      for (int k = 0; k < 5; k++) begin
         writeByte(BASE, 8'(8'hA0 + k), 1, 1'b0, 1'b0);
         writeByte(BASE, 8'(8'h50 + k), 1, 1'b0, 1'b0);
      end
      statusRead(1'b0);
      checkOutput("statC4", 32'(lastStatus), 32'hC4);
      checkOutput("ovfCleared", 32'(overflow), 32'h0);
      statusRead(1'b0);
      checkOutput("stat44", 32'(lastStatus), 32'h44);
      for (int k = 0; k < 4; k++) begin
         checkOutput("drainOrder", 32'(outData), 32'({8'(8'hA0 + k), 8'(8'h50 + k)}));
         idle(1, 1'b1);
      end
      checkOutput("drainEmpty", 32'(outValid), 32'h0);

      // Full FIFO with a pop on the commit edge keeps the word
      for (int k = 0; k < 4; k++) begin
         writeByte(BASE, 8'(8'hC0 + k), 1, 1'b0, 1'b0);
         writeByte(BASE, 8'(8'h60 + k), 1, 1'b0, 1'b0);
      end
      writeByte(BASE, 8'hC4, 1, 1'b0, 1'b0);
      writeByte(BASE, 8'h64, 1, 1'b0, 1'b1);
      checkOutput("fullPopNoOvf", 32'(overflow), 32'h0);
      statusRead(1'b0);
      checkOutput("fullPopStat", 32'(lastStatus), 32'h44);
      for (int k = 1; k < 5; k++) begin
         checkOutput("fullPopOrder", 32'(outData), 32'({8'(8'hC0 + k), 8'(8'h60 + k)}));
         idle(1, 1'b1);
      end

      // Flush after a lone high byte
      writeByte(BASE, 8'h22, 1, 1'b0, 1'b0);
      writeByte(BASE, 8'h33, 1, 1'b0, 1'b0);
      writeByte(BASE, 8'h11, 1, 1'b0, 1'b0);
      writeByte(CTRL, 8'h01, 1, 1'b0, 1'b0);
      checkOutput("flushEmpty", 32'(outValid), 32'h0);
      statusRead(1'b0);
      checkOutput("flushStat", 32'(lastStatus), 32'h00);
      writeByte(BASE, 8'h56, 1, 1'b0, 1'b0);
      writeByte(BASE, 8'h78, 1, 1'b0, 1'b0);
      checkOutput("flush5678", 32'(outData), 32'h5678);
      idle(1, 1'b1);

      // Reset between the bytes of a pair
      writeByte(BASE, 8'h77, 1, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b1, 16'h0000, 8'h00, 1'b0);
      writeByte(BASE, 8'h9A, 1, 1'b0, 1'b0);
      writeByte(BASE, 8'hBC, 1, 1'b0, 1'b0);
      checkOutput("rst9ABC", 32'(outData), 32'h9ABC);

      // Undecoded reads and idle bus leave data to other drivers
      forceDrive = 1'b1;
      applyStimulus(1'b0, 1'b1, 1'b0, BASE, 8'h3C, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0, CTRL, 8'hC3, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b1, STAT, 8'hE7, 1'b0);
      forceDrive = 1'b0;
      idle(1, 1'b1);

      // Randomized bus traffic
      for (int n = 0; n < 400; n++) begin
         int unsigned op;
         logic rdy;
         op  = $urandom_range(0, 9);
         rdy = 1'($urandom_range(0, 1));
         if (op <= 5) begin
            writeByte(BASE, 8'($urandom), int'($urandom_range(1, 3)), rdy, 1'($urandom_range(0, 1)));
         end else if (op == 6) begin
            writeByte(CTRL, {7'($urandom), 1'($urandom_range(0, 5) == 0)}, 1, rdy, rdy);
         end else if (op == 7) begin
            applyStimulus(1'b0, 1'b1, 1'b0, STAT, 8'h00, rdy);
            applyStimulus(1'b0, 1'b1, 1'b1, STAT, 8'h00, 1'($urandom_range(0, 1)));
         end else if (op == 8) begin
            idle(1, rdy);
         end else begin
            if ($urandom_range(0, 19) == 0) applyStimulus(1'b1, 1'b1, 1'b1, 16'h0000, 8'h00, rdy);
            else idle(1, rdy);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
